// File: rtl/dmi_arbiter.sv
// Two-requester DMI arbiter between the JTAG DTM (m0) and a secondary debug
// master (m1). The two requesters take turns when both are waiting. Each side
// uses a four-phase req/ack handshake. A transaction with no downstream ack
// ends in a timeout failure.
module dmi_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              jtag_tck_i,
    input  logic              jtag_trstn_i,

    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_we_i,
    output logic              m0_ack_o,
    output logic [1:0]        m0_op_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rdata_valid_o,

    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_we_i,
    output logic              m1_ack_o,
    output logic [1:0]        m1_op_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rdata_valid_o,

    output logic              dmi_req_o,
    output logic [ADDR_W-1:0] dmi_addr_o,
    output logic [DATA_W-1:0] dmi_wdata_o,
    output logic              dmi_we_o,
    input  logic              dmi_ack_i,
    input  logic [1:0]        dmi_op_i,
    input  logic [DATA_W-1:0] dmi_rdata_i,
    input  logic              dmi_rdata_valid_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [1:0] OpFailed    = 2'd2;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;    // 0: m0 was served last, 1: m1
    logic                    owner_q, owner_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    dmi_req_q, dmi_req_d;
    logic [ADDR_W-1:0]       dmi_addr_q, dmi_addr_d;
    logic [DATA_W-1:0]       dmi_wdata_q, dmi_wdata_d;
    logic                    dmi_we_q, dmi_we_d;
    logic [1:0]              grant_q, grant_d;
    logic                    timeout_q, timeout_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0][1:0]         op_q, op_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]              rvalid_q, rvalid_d;

    logic sel;
    logic owner_req;

    // Requester picked in IDLE: alternate when both wait, otherwise the only one.
    always_comb begin
        if (m0_req_i && m1_req_i) begin
            sel = ~last_q;
        end else begin
            sel = m1_req_i;
        end
        owner_req = owner_q ? m1_req_i : m0_req_i;
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        dmi_req_d   = dmi_req_q;
        dmi_addr_d  = dmi_addr_q;
        dmi_wdata_d = dmi_wdata_q;
        dmi_we_d    = dmi_we_q;
        grant_d     = grant_q;
        timeout_d   = 1'b0;
        ack_d       = ack_q;
        op_d        = op_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;

        unique case (state_q)
            StIdle: begin
                if ((m0_req_i || m1_req_i) && !dmi_ack_i) begin
                    state_d     = StReq;
                    owner_d     = sel;
                    last_d      = sel;
                    cnt_d       = 8'd0;
                    dmi_req_d   = 1'b1;
                    dmi_addr_d  = sel ? m1_addr_i  : m0_addr_i;
                    dmi_wdata_d = sel ? m1_wdata_i : m0_wdata_i;
                    dmi_we_d    = sel ? m1_we_i    : m0_we_i;
                    grant_d     = sel ? 2'b10 : 2'b01;
                end
            end
            StReq: begin
                // An ack arriving on the expiry cycle still wins over the timeout.
                if (dmi_ack_i) begin
                    state_d           = StResp;
                    dmi_req_d         = 1'b0;
                    ack_d[owner_q]    = 1'b1;
                    op_d[owner_q]     = dmi_op_i;
                    rdata_d[owner_q]  = dmi_rdata_i;
                    rvalid_d[owner_q] = dmi_rdata_valid_i;
                end else if (cnt_q == TimeoutLast) begin
                    state_d           = StResp;
                    dmi_req_d         = 1'b0;
                    ack_d[owner_q]    = 1'b1;
                    op_d[owner_q]     = OpFailed;
                    rdata_d[owner_q]  = '0;
                    rvalid_d[owner_q] = 1'b0;
                    timeout_d         = 1'b1;
                end else if (cnt_q != 8'hff) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                // Waiting for dmi_ack_i low also swallows a late ack after a timeout.
                if (!owner_req && !dmi_ack_i) begin
                    state_d  = StIdle;
                    grant_d  = 2'b00;
                    ack_d    = '0;
                    op_d     = '0;
                    rdata_d  = '0;
                    rvalid_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset clears everything and favours m0 first.
    always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
        if (!jtag_trstn_i) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= 8'd0;
            dmi_req_q   <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= '0;
            dmi_we_q    <= 1'b0;
            grant_q     <= 2'b00;
            timeout_q   <= 1'b0;
            ack_q       <= '0;
            op_q        <= '0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            dmi_req_q   <= dmi_req_d;
            dmi_addr_q  <= dmi_addr_d;
            dmi_wdata_q <= dmi_wdata_d;
            dmi_we_q    <= dmi_we_d;
            grant_q     <= grant_d;
            timeout_q   <= timeout_d;
            ack_q       <= ack_d;
            op_q        <= op_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign m0_ack_o         = ack_q[0];
    assign m0_op_o          = op_q[0];
    assign m0_rdata_o       = rdata_q[0];
    assign m0_rdata_valid_o = rvalid_q[0];
    assign m1_ack_o         = ack_q[1];
    assign m1_op_o          = op_q[1];
    assign m1_rdata_o       = rdata_q[1];
    assign m1_rdata_valid_o = rvalid_q[1];
    assign dmi_req_o        = dmi_req_q;
    assign dmi_addr_o       = dmi_addr_q;
    assign dmi_wdata_o      = dmi_wdata_q;
    assign dmi_we_o         = dmi_we_q;
    assign grant_o          = grant_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed table, a reset-in-flight sequence, and
// randomized transactions against a transaction-level round-robin model.
module tb_dmi_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        trstn = 1'b1;
    logic [1:0]  rq = 2'b00;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        wev [2];
    logic        dmi_ack = 1'b0;
    logic [1:0]  dmi_op = 2'd0;
    logic [31:0] dmi_rdata = '0;
    logic        dmi_rv = 1'b0;

    logic        m0_ack_o, m1_ack_o, m0_rdata_valid_o, m1_rdata_valid_o;
    logic [1:0]  m0_op_o, m1_op_o, grant_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, dmi_addr_o, dmi_wdata_o;
    logic        dmi_req_o, dmi_we_o, timeout_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        last_m = 1'b1;   // model: requester served most recently

    always #5 clk = ~clk;

    dmi_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(32), .DATA_W(32)) dut (
        .jtag_tck_i        (clk),
        .jtag_trstn_i      (trstn),
        .m0_req_i          (rq[0]),
        .m0_addr_i         (ad[0]),
        .m0_wdata_i        (wd[0]),
        .m0_we_i           (wev[0]),
        .m0_ack_o          (m0_ack_o),
        .m0_op_o           (m0_op_o),
        .m0_rdata_o        (m0_rdata_o),
        .m0_rdata_valid_o  (m0_rdata_valid_o),
        .m1_req_i          (rq[1]),
        .m1_addr_i         (ad[1]),
        .m1_wdata_i        (wd[1]),
        .m1_we_i           (wev[1]),
        .m1_ack_o          (m1_ack_o),
        .m1_op_o           (m1_op_o),
        .m1_rdata_o        (m1_rdata_o),
        .m1_rdata_valid_o  (m1_rdata_valid_o),
        .dmi_req_o         (dmi_req_o),
        .dmi_addr_o        (dmi_addr_o),
        .dmi_wdata_o       (dmi_wdata_o),
        .dmi_we_o          (dmi_we_o),
        .dmi_ack_i         (dmi_ack),
        .dmi_op_i          (dmi_op),
        .dmi_rdata_i       (dmi_rdata),
        .dmi_rdata_valid_i (dmi_rv),
        .grant_o           (grant_o),
        .timeout_o         (timeout_o)
    );

    typedef struct {
        logic [1:0]  r;      // requesters newly raising req
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] w;
        logic        we;
        int          d;      // cycles before DM ack, -1 = never
        logic [1:0]  op;
        logic [31:0] rd;
        logic        rv;
        int          hold;   // extra cycles DM keeps ack high after response
        logic [1:0]  eg;
        logic [1:0]  eop;
        logic [31:0] erd;
        logic        erv;
        logic        eto;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input int n);
        return (n == 1) ? m1_ack_o : m0_ack_o;
    endfunction

    function automatic logic [34:0] resp_of(input int n);
        return (n == 1) ? {m1_op_o, m1_rdata_valid_o, m1_rdata_o}
                        : {m0_op_o, m0_rdata_valid_o, m0_rdata_o};
    endfunction

    task automatic do_reset();
        trstn = 1'b0;
        rq = 2'b00;
        dmi_ack = 1'b0;
        dmi_op = 2'd0;
        dmi_rdata = '0;
        dmi_rv = 1'b0;
        @(posedge clk);
        #1;
        trstn = 1'b1;
        last_m = 1'b1;
    endtask

    task automatic raise(input int n, input logic [31:0] a, input logic [31:0] w, input logic we);
        ad[n] = a;
        wd[n] = w;
        wev[n] = we;
        rq[n] = 1'b1;
    endtask

    // One full transaction: grant, DM response (or timeout), release, return to IDLE.
    task automatic txn(input logic [1:0] eg, input int d, input logic [1:0] op,
                       input logic [31:0] rd, input logic rv, input int hold,
                       input logic [1:0] eop, input logic [31:0] erd, input logic erv,
                       input logic eto);
        int own, oth, c, n;
        logic seen;
        own = eg[1] ? 1 : 0;
        oth = 1 - own;
        for (int i = 0; i < 4 && !dmi_req_o; i++) begin
            @(posedge clk);
            #1;
        end
        chk("dmi_req_rise", dmi_req_o, 1);
        if (!dmi_req_o) begin
            do_reset();
            return;
        end
        chk("grant", grant_o, eg);
        chk("dmi_addr", dmi_addr_o, ad[own]);
        chk("dmi_wdata", dmi_wdata_o, wd[own]);
        chk("dmi_we", dmi_we_o, wev[own]);
        last_m = own[0];

        c = 0;
        seen = 1'b0;
        while (c < TIMEOUT + 4) begin
            if (d >= 0 && c == d) begin
                dmi_ack = 1'b1;
                dmi_op = op;
                dmi_rdata = rd;
                dmi_rv = rv;
            end
            @(posedge clk);
            #1;
            c++;
            if (ack_of(own)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("owner_ack", seen, 1);
        if (!seen) begin
            do_reset();
            return;
        end
        chk("ack_latency", c, eto ? TIMEOUT : d + 1);
        chk("owner_resp", resp_of(own), {eop, erv, erd});
        chk("timeout_pulse", timeout_o, eto);
        chk("dmi_req_fall", dmi_req_o, 0);
        chk("nonowner_quiet", {ack_of(oth), resp_of(oth)}, 0);

        rq[own] = 1'b0;
        if (hold > 0) begin
            dmi_ack = 1'b1;
            if (eto) begin
                dmi_op = 2'd0;
                dmi_rdata = '0;
                dmi_rv = 1'b0;
            end
        end else begin
            dmi_ack = 1'b0;
        end
        n = 0;
        while (n < hold + 6) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("timeout_one_cycle", timeout_o, 0);
            if (n >= hold) dmi_ack = 1'b0;
            if (grant_o == 2'b00) break;
        end
        chk("idle_latency", n, hold + 1);
        chk("owner_cleared", {ack_of(own), resp_of(own)}, 0);
        chk("idle_dmi_req", dmi_req_o, 0);
        dmi_op = 2'd0;
        dmi_rdata = '0;
        dmi_rv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, own;
        logic [1:0] op, eg;
        logic [31:0] rd;
        logic rv, eto;

        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0; wev[0] = 0; wev[1] = 0;

        //          r      a0     a1     w             we d   op rd            rv hold eg     eop erd           erv eto
        vecs[0] = '{2'b01, 32'h8c, 32'h0, 32'h0a,       1, 3, 0, 32'h0,        0, 4, 2'b01, 0, 32'h0,        0, 0};
        vecs[1] = '{2'b10, 32'h0,  32'h8c, 32'h0,       0, 1, 0, 32'h123,      1, 0, 2'b10, 0, 32'h123,      1, 0};
        vecs[2] = '{2'b11, 32'h10, 32'h14, 32'h11,      1, 0, 0, 32'h0,        0, 1, 2'b01, 0, 32'h0,        0, 0};
        vecs[3] = '{2'b01, 32'h20, 32'h0,  32'h21,      1, 0, 0, 32'h0,        0, 0, 2'b10, 0, 32'h0,        0, 0};
        vecs[4] = '{2'b10, 32'h0,  32'h24, 32'h25,      0, 1, 0, 32'h9,        1, 0, 2'b01, 0, 32'h9,        1, 0};
        vecs[5] = '{2'b00, 32'h0,  32'h0,  32'h0,       0, 0, 0, 32'h0,        0, 2, 2'b10, 0, 32'h0,        0, 0};
        vecs[6] = '{2'b01, 32'h30, 32'h0,  32'h0,       0, 2, 3, 32'hdeadbeef, 1, 0, 2'b01, 3, 32'hdeadbeef, 1, 0};
        vecs[7] = '{2'b10, 32'h0,  32'h34, 32'h0,       0, 7, 0, 32'h55,       1, 0, 2'b10, 0, 32'h55,       1, 0};
        vecs[8] = '{2'b01, 32'h38, 32'h0,  32'h0,       0, -1, 0, 32'h0,       0, 3, 2'b01, 2, 32'h0,        0, 1};
        vecs[9] = '{2'b01, 32'h3c, 32'h0,  32'h3d,      1, 0, 0, 32'h77,       1, 0, 2'b01, 0, 32'h77,       1, 0};

        #2 trstn = 1'b0;
        #2;
        chk("rst_dmi_req", dmi_req_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_acks", {m0_ack_o, m1_ack_o, timeout_o}, 0);
        chk("rst_resp", {resp_of(0), resp_of(1)}, 0);
        @(posedge clk);
        #1;
        trstn = 1'b1;
        last_m = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].r[0]) raise(0, vecs[i].a0, vecs[i].w, vecs[i].we);
            if (vecs[i].r[1]) raise(1, vecs[i].a1, vecs[i].w, vecs[i].we);
            txn(vecs[i].eg, vecs[i].d, vecs[i].op, vecs[i].rd, vecs[i].rv, vecs[i].hold,
                vecs[i].eop, vecs[i].erd, vecs[i].erv, vecs[i].eto);
        end

        // Reset while a transaction is outstanding, then a fresh m1 request.
        raise(0, 32'h40, 32'h41, 1'b1);
        for (int i = 0; i < 4 && !dmi_req_o; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_req", dmi_req_o, 1);
        trstn = 1'b0;
        #1;
        chk("async_rst_req", dmi_req_o, 0);
        chk("async_rst_grant", grant_o, 0);
        chk("async_rst_bus", {dmi_addr_o, dmi_wdata_o, dmi_we_o}, 0);
        rq = 2'b00;
        @(posedge clk);
        #1;
        trstn = 1'b1;
        last_m = 1'b1;
        raise(1, 32'h44, 32'h45, 1'b0);
        txn(2'b10, 1, 2'd0, 32'hab, 1'b1, 0, 2'd0, 32'hab, 1'b1, 1'b0);

        // Randomized transactions against the round-robin / timeout model.
        for (int t = 0; t < 60; t++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] && $urandom_range(0, 1) == 1)
                    raise(n, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            if (rq == 2'b00) raise(int'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
            own = (rq[0] && rq[1]) ? int'(!last_m) : int'(rq[1]);
            eg = (own == 1) ? 2'b10 : 2'b01;
            d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT));
            case ($urandom_range(0, 2))
                0: op = 2'd0;
                1: op = 2'd2;
                default: op = 2'd3;
            endcase
            rd = $urandom;
            rv = 1'($urandom_range(0, 1));
            eto = (d < 0) || (d >= TIMEOUT);
            if (eto)
                txn(eg, d, op, rd, rv, int'($urandom_range(0, 3)), 2'd2, 32'h0, 1'b0, 1'b1);
            else
                txn(eg, d, op, rd, rv, int'($urandom_range(0, 3)), op, rd, rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
